// File: rtl/commutator_p2s.sv
// Polyphase output commutator: captures one vector of gp_nr_phases words on a
// load strobe and emits them one per enabled edge, in phase order.
module commutator_p2s #(
  parameter int gp_data_width = 8,
  parameter int gp_nr_phases  = 4,
  parameter int gp_reverse    = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_an,
  input  logic                                    i_ena,
  input  logic                                    i_load,
  input  logic [gp_nr_phases*gp_data_width-1:0]   i_data,
  input  logic                                    i_clr_ovr,
  output logic [gp_data_width-1:0]                o_data,
  output logic                                    o_valid,
  output logic [((gp_nr_phases > 2) ? $clog2(gp_nr_phases) : 1)-1:0] o_phase,
  output logic                                    o_first,
  output logic                                    o_last,
  output logic                                    o_busy,
  output logic                                    o_overrun
);

  // state | meaning
  // IDLE  | no vector in flight, outputs zero
  // SHIFT | emitting words of the captured vector
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int W         = gp_data_width;
  localparam int N         = gp_nr_phases;
  localparam int PW        = (N > 2) ? $clog2(N) : 1;
  localparam int FIRST_IDX = (gp_reverse != 0) ? N - 1 : 0;
  localparam logic [PW-1:0] FIRST_PH = PW'(FIRST_IDX);

  logic          r_state;
  logic [W-1:0]  r_buf [N];
  logic [PW-1:0] r_phase;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_first;
  logic          r_last;
  logic          r_overrun;

  logic [PW-1:0] w_next_phase;
  logic [PW-1:0] w_last_ph;
  logic          w_set_ovr;

  assign w_last_ph    = (gp_reverse != 0) ? '0 : PW'(N - 1);
  assign w_next_phase = (gp_reverse != 0) ? r_phase - PW'(1) : r_phase + PW'(1);
  // A load while words of the current vector are still pending drops them.
  assign w_set_ovr    = i_ena && i_load && (r_state == ST_SHIFT) && !r_last;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state <= ST_IDLE;
      for (int k = 0; k < N; k++) r_buf[k] <= '0;
      r_phase <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_ena) begin
      if (i_load) begin
        for (int k = 0; k < N; k++) r_buf[k] <= i_data[k*W +: W];
        r_state <= ST_SHIFT;
        r_phase <= FIRST_PH;
        r_data  <= i_data[FIRST_IDX*W +: W];
        r_valid <= 1'b1;
        r_first <= 1'b1;
        r_last  <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
        if (r_last) begin
          r_state <= ST_IDLE;
          r_phase <= '0;
          r_data  <= '0;
          r_valid <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_phase <= w_next_phase;
          r_data  <= r_buf[w_next_phase];
          r_first <= 1'b0;
          r_last  <= (w_next_phase == w_last_ph);
        end
      end
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_overrun <= 1'b0;
    end else if (w_set_ovr) begin
      r_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_phase   = r_phase;
  assign o_first   = r_first;
  assign o_last    = r_last;
  assign o_busy    = (r_state == ST_SHIFT);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_commutator_p2s.sv
// Directed bench for commutator_p2s: forward and reversed instances share the
// stimulus; expected words are queued at load time and popped per enabled edge.
module tb_commutator_p2s;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] p;
    logic       f;
    logic       l;
    logic       v;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_an = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic        clr = 1'b0;

  logic [7:0] f_data, r_data;
  logic       f_valid, r_valid, f_first, r_first, f_last, r_last;
  logic       f_busy, r_busy, f_ovr, r_ovr;
  logic [1:0] f_phase, r_phase;

  ent_t fq[$], rq[$];
  ent_t f_cur, r_cur;
  logic exp_ovr;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] V1 = 32'h4433_2211;
  localparam logic [31:0] V2 = 32'h8877_6655;

  always #5 clk = ~clk;

  commutator_p2s #(.gp_data_width(8), .gp_nr_phases(4), .gp_reverse(0)) u_fwd (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_load(load), .i_data(data),
    .i_clr_ovr(clr), .o_data(f_data), .o_valid(f_valid), .o_phase(f_phase),
    .o_first(f_first), .o_last(f_last), .o_busy(f_busy), .o_overrun(f_ovr));

  commutator_p2s #(.gp_data_width(8), .gp_nr_phases(4), .gp_reverse(1)) u_rev (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_load(load), .i_data(data),
    .i_clr_ovr(clr), .o_data(r_data), .o_valid(r_valid), .o_phase(r_phase),
    .o_first(r_first), .o_last(r_last), .o_busy(r_busy), .o_overrun(r_ovr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " fwd data"},  32'(f_data),  32'(f_cur.d));
    chk({tag, " fwd valid"}, 32'(f_valid), 32'(f_cur.v));
    chk({tag, " fwd phase"}, 32'(f_phase), 32'(f_cur.p));
    chk({tag, " fwd first"}, 32'(f_first), 32'(f_cur.f));
    chk({tag, " fwd last"},  32'(f_last),  32'(f_cur.l));
    chk({tag, " fwd busy"},  32'(f_busy),  32'(f_cur.v));
    chk({tag, " fwd ovr"},   32'(f_ovr),   32'(exp_ovr));
    chk({tag, " rev data"},  32'(r_data),  32'(r_cur.d));
    chk({tag, " rev valid"}, 32'(r_valid), 32'(r_cur.v));
    chk({tag, " rev phase"}, 32'(r_phase), 32'(r_cur.p));
    chk({tag, " rev first"}, 32'(r_first), 32'(r_cur.f));
    chk({tag, " rev last"},  32'(r_last),  32'(r_cur.l));
    chk({tag, " rev busy"},  32'(r_busy),  32'(r_cur.v));
    chk({tag, " rev ovr"},   32'(r_ovr),   32'(exp_ovr));
  endtask

  // One clock edge of stimulus; expectation is built from the queues.
  task automatic tick(input string tag, input logic e, input logic ld,
                      input logic [31:0] vec, input logic c);
    logic set;
    ena = e; load = ld; data = vec; clr = c;
    set = 1'b0;
    if (e && ld) begin
      set = (fq.size() > 0);
      fq.delete();
      rq.delete();
      for (int k = 0; k < 4; k++) begin
        fq.push_back('{d: vec[k*8 +: 8], p: 2'(k), f: (k == 0), l: (k == 3), v: 1'b1});
        rq.push_back('{d: vec[(3-k)*8 +: 8], p: 2'(3-k), f: (k == 0), l: (k == 3), v: 1'b1});
      end
    end
    @(posedge clk);
    #1;
    if (set) exp_ovr = 1'b1;
    else if (c) exp_ovr = 1'b0;
    if (e) begin
      f_cur = (fq.size() > 0) ? fq.pop_front() : '0;
      r_cur = (rq.size() > 0) ? rq.pop_front() : '0;
    end
    check_all(tag);
  endtask

  initial begin
    f_cur = '0; r_cur = '0; exp_ovr = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_an = 1'b1;
    tick("idle", 1, 0, V1, 0);

    // Single vector then drop to idle
    tick("single ld", 1, 1, V1, 0);
    repeat (3) tick("single sh", 1, 0, V1, 0);
    tick("single end", 1, 0, V1, 0);

    // Back-to-back on o_last, no gap
    tick("b2b ld1", 1, 1, V1, 0);
    repeat (3) tick("b2b sh1", 1, 0, V1, 0);
    tick("b2b ld2", 1, 1, V2, 0);
    repeat (3) tick("b2b sh2", 1, 0, V1, 0);
    tick("b2b end", 1, 0, V1, 0);

    // Overrun mid-vector, sticky, clear, then set+clear same edge
    tick("ovr ld1", 1, 1, V1, 0);
    tick("ovr sh", 1, 0, V1, 0);
    tick("ovr ld2", 1, 1, V2, 0);
    repeat (3) tick("ovr sh2", 1, 0, V1, 0);
    tick("ovr end", 1, 0, V1, 0);
    tick("ovr hold", 0, 0, V1, 0);
    tick("ovr clr", 0, 0, V1, 1);
    tick("ovr ld3", 1, 1, V1, 0);
    tick("ovr setclr", 1, 1, V2, 1);
    repeat (3) tick("ovr sh3", 1, 0, V1, 0);
    tick("ovr end3", 1, 0, V1, 0);
    tick("ovr clr2", 1, 0, V1, 1);

    // Enable gating; a load with ena low is ignored
    tick("ena ld", 1, 1, V1, 0);
    tick("ena sh", 1, 0, V1, 0);
    tick("ena off", 0, 0, V1, 0);
    tick("ena off ld", 0, 1, V2, 0);
    repeat (2) tick("ena on", 1, 0, V1, 0);
    tick("ena end", 1, 0, V1, 0);

    // Async reset mid-vector
    tick("rst ld", 1, 1, V1, 0);
    repeat (2) tick("rst sh", 1, 0, V1, 0);
    @(negedge clk);
    rst_an = 1'b0;
    #1;
    fq.delete(); rq.delete();
    f_cur = '0; r_cur = '0; exp_ovr = 1'b0;
    check_all("rst async");
    @(negedge clk);
    rst_an = 1'b1;
    tick("rst post ld", 1, 1, V2, 0);
    repeat (3) tick("rst post sh", 1, 0, V1, 0);
    tick("rst post end", 1, 0, V1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commutator_p2s.md
Name: commutator_p2s

Overview:
- Output commutator for polyphase filters: parallel-in, serial-out.
- Captures one low-rate vector holding gp_nr_phases sub-filter results and emits the words one per high-rate enable, in phase order.
- Counterpart of the input-side delay-line shift register: that block serialises history into taps, this block serialises phase outputs back to the high-rate stream.
- Sits between the polyphase branch adders and the interpolator output.

Parameters:
- gp_data_width, 8, bit-width of each phase word (signed, MSB:LSB).
- gp_nr_phases, 4, number of phases/words per load; must be >= 2.
- gp_reverse, 0, 0 = emit phase 0 first; 1 = emit phase gp_nr_phases-1 first.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_an  in  1  asynchronous active-low reset.
- i_ena  in  1  synchronous active-high high-rate enable; all state holds when 0.
- i_load  in  1  load strobe; sampled only when i_ena=1.
- i_data  in  gp_nr_phases*gp_data_width  phase k word at bits [(k+1)*W-1 : k*W], signed.
- i_clr_ovr  in  1  synchronous clear of o_overrun; independent of i_ena.
- o_data  out  gp_data_width  current serial output word, registered.
- o_valid  out  1  o_data holds a phase word.
- o_phase  out  max(1,$clog2(gp_nr_phases))  phase index of o_data.
- o_first  out  1  o_valid and this is the first word of a vector.
- o_last  out  1  o_valid and this is the last word of a vector.
- o_busy  out  1  state is SHIFT.
- o_overrun  out  1  sticky: a load arrived before the current vector was fully emitted.

Behaviour:
- Reset (async, i_rst_an=0):
  - State IDLE.
  - o_data=0, o_valid=0, o_phase=0, o_first=0, o_last=0, o_busy=0, o_overrun=0.
  - Internal buffer and counter cleared.
- Reset applied mid-vector aborts it immediately. The first load after release starts cleanly.
- All transitions below occur only on rising edges with i_ena=1, except i_clr_ovr.
- State IDLE:
  - i_load=1: capture i_data, then o_data <= first word (phase 0, or phase N-1 if gp_reverse=1).
  - Same edge: o_phase = that index, o_valid=1, o_first=1, o_busy=1, go to SHIFT.
  - Latency from load edge to first word: 1 edge, registered.
  - i_load=0: outputs stay 0 / invalid.
- State SHIFT, i_load=0:
  - Each i_ena edge advances to the next phase: index +1, or -1 if reversed.
  - o_first=0. o_last=1 exactly while the final phase is on o_data.
  - Edge after o_last: o_valid=0, o_data=0, o_busy=0, o_first=0, o_last=0, o_phase=0, go to IDLE.
- State SHIFT, i_load=1 while o_last=1: seamless back-to-back.
  - New vector captured and first word emitted on that edge.
  - Stay in SHIFT, no gap, no overrun.
- State SHIFT, i_load=1 while o_last=0: overrun.
  - Remaining old words are discarded.
  - New vector restarts at the first phase, o_first=1.
  - o_overrun <= 1.
- o_overrun:
  - Stays set until i_clr_ovr=1 at a clock edge.
  - If a set event and i_clr_ovr occur on the same edge, set wins.
- Vector cadence: a new vector every gp_nr_phases enabled edges gives a continuous stream at 1 word per enable.
- No arithmetic on data: words pass bit-exact, with no sign extension or rounding.
- The phase counter never exceeds gp_nr_phases-1. Wrap is handled only by the state rules above.

Test Plan (W=8, N=4, i_data={8'h44,8'h33,8'h22,8'h11}):
- Reset, then a single load with continuous i_ena -> o_data 11,22,33,44 on 4 consecutive edges.
  - o_phase 0..3; o_first on 11, o_last on 44.
  - Next edge: o_valid=0, o_data=0, o_busy=0; o_overrun=0.
- Reload exactly when o_last=1 with {88,77,66,55} -> stream 11,22,33,44,55,66,77,88 with no invalid gap; o_overrun=0.
- Reload when o_phase=1 (o_data=22) -> next edge o_data=55 (new vector's first word), o_first=1.
  - o_overrun=1 and held.
  - Pulse i_clr_ovr -> 0. Set and clear on the same edge -> stays 1.
- i_ena toggled 1,0,0,1 during shift -> o_data/o_phase hold across the i_ena=0 cycles; i_load asserted with i_ena=0 is ignored.
- gp_reverse=1 -> order 44,33,22,11 with o_phase 3,2,1,0.
- Assert i_rst_an=0 asynchronously while o_data=33 -> all outputs 0 immediately.
  - After release, a new load emits from phase 0.
